// File: rtl/sgpio_pkg.sv
// sgpio_pkg: shared SGPIO word width, idle level and bit-counter sizing
package sgpio_pkg;
    localparam int   SGPIO_WIDTH    = 8;
    localparam logic SGPIO_IDLE_BIT = 1'b0;
    function automatic int sgpio_cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
    localparam int   SGPIO_CNT_W    = sgpio_cnt_w(SGPIO_WIDTH);
endpackage

// File: rtl/sgpio_sync_edge.sv
// sgpio_sync_edge: multi-flop synchronizer for an asynchronous pin plus rising-edge detect
module sgpio_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);
    logic [STAGES-1:0] sync;
    logic              q_d;
    // shift the pin through the synchronizer and keep one delayed copy for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {STAGES{RST_VAL}};
            q_d  <= RST_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            q_d  <= sync[STAGES-1];
        end
    end
    assign q    = sync[STAGES-1];
    assign rise = q & ~q_d;
endmodule

// File: rtl/sgpio_serial_tx.sv
// sgpio_serial_tx: SGPIO transmit shifter, LSB-first on qualified SGPIO clock edges (option: SGPIO_TX_UNDERRUN_CNT_EN)
module sgpio_serial_tx
    import sgpio_pkg::*;
#(
    parameter int   WIDTH       = SGPIO_WIDTH,
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_BIT    = SGPIO_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sgpio_clk_in,
    input  logic             sgpio_en_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sgpio_dout,
    output logic             busy,
`ifdef SGPIO_TX_UNDERRUN_CNT_EN
    output logic             underrun,
    output logic [7:0]       underrun_cnt
`else
    output logic             underrun
`endif
);
    localparam int CW = sgpio_cnt_w(WIDTH);

    logic             clk_rise, en_n_s, en_rise_unused, tick;
    logic             hold_full, sr_valid, last, load, accept;
    logic [WIDTH-1:0] hold, sr;
    logic [CW-1:0]    bit_cnt;

    sgpio_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
        .clk(clk), .rst(rst), .d(sgpio_clk_in), .q(), .rise(clk_rise)
    );
    sgpio_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_en_sync (
        .clk(clk), .rst(rst), .d(sgpio_en_n), .q(en_n_s), .rise(en_rise_unused)
    );

    assign tick     = clk_rise & ~en_n_s;
    assign last     = bit_cnt == CW'(WIDTH - 1);
    assign load     = hold_full & (~sr_valid | (tick & last));
    assign tx_ready = ~hold_full & ~rst;
    assign accept   = tx_valid & tx_ready;
    assign busy     = sr_valid | hold_full;

    // holding register, shifter and registered serial output; reload on the last tick keeps words gapless
    always_ff @(posedge clk) begin
        if (rst) begin
            hold       <= '0;
            hold_full  <= 1'b0;
            sr         <= '0;
            sr_valid   <= 1'b0;
            bit_cnt    <= '0;
            sgpio_dout <= IDLE_BIT;
            underrun   <= 1'b0;
        end else begin
            underrun   <= tick & ~sr_valid;
            sgpio_dout <= sr_valid ? sr[0] : IDLE_BIT;
            if (load) begin
                sr       <= hold;
                sr_valid <= 1'b1;
                bit_cnt  <= '0;
            end else if (tick & sr_valid & last) begin
                sr_valid <= 1'b0;
            end else if (tick & sr_valid) begin
                sr      <= sr >> 1;
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (accept) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

`ifdef SGPIO_TX_UNDERRUN_CNT_EN
    // saturating count of underrun pulses
    always_ff @(posedge clk) begin
        if (rst) underrun_cnt <= '0;
        else if (underrun && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
`endif
endmodule
